// File: rtl/hrm_inbox.sv
// CPU INBOX mailbox: host-pushed bytes, first-word-fall-through to the CPU,
// with occupancy and sticky overflow/underflow flags for debug.
module hrm_inbox #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  cpu_in_wr,
    input  logic [WIDTH-1:0]      cpu_in_data,
    output logic                  cpu_in_full,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    input  logic                  i_clr,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full;
    logic                  empty;
    logic                  push_acc;
    logic                  pop_acc;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == CW'(0));

    // Clear wins over any strobe; a full FIFO refuses a push even alongside a pop.
    assign push_acc = cpu_in_wr & ~full  & ~i_clr;
    assign pop_acc  = i_pop     & ~empty & ~i_clr;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (i_clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (push_acc) wp_d = wp_q + DEPTH_LOG2'(1);
            if (pop_acc)  rp_d = rp_q + DEPTH_LOG2'(1);
            if (cpu_in_wr && full) ovf_d = 1'b1;
            if (i_pop && empty)    udf_d = 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage carries no reset; stale words are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wp_q] <= cpu_in_data;
    end

    assign o_data      = mem_q[rp_q];
    assign o_empty     = empty;
    assign cpu_in_full = full;
    assign o_count     = cnt_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule

// File: tb/tb_hrm_inbox.sv
// Bench for hrm_inbox: directed test-plan scenarios plus random traffic,
// all checked every cycle against a queue-based mailbox model.
module tb_hrm_inbox;

    localparam int unsigned DL2   = 3;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 1 << DL2;

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         cpu_in_wr = 1'b0;
    logic [W-1:0] cpu_in_data = '0;
    logic         cpu_in_full;
    logic         i_pop = 1'b0;
    logic [W-1:0] o_data;
    logic         o_empty;
    logic [DL2:0] o_count;
    logic         i_clr = 1'b0;
    logic         o_overflow;
    logic         o_underflow;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: contents as a queue, flags as plain bits.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    hrm_inbox #(.DEPTH_LOG2(DL2), .WIDTH(W)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .cpu_in_wr  (cpu_in_wr),
        .cpu_in_data(cpu_in_data),
        .cpu_in_full(cpu_in_full),
        .i_pop      (i_pop),
        .o_data     (o_data),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .i_clr      (i_clr),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit wr, input logic [W-1:0] d, input bit pop, input bit clr);
        bit was_full;
        bit was_empty;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (wr && was_full)  m_ovf = 1'b1;
            if (pop && was_empty) m_udf = 1'b1;
            if (pop && !was_empty) void'(mq.pop_front());
            if (wr && !was_full)  mq.push_back(d);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock: drive, take the edge, advance the model, land on the falling edge.
    task automatic cycle(input bit wr, input logic [W-1:0] d, input bit pop, input bit clr);
        cpu_in_wr   = wr;
        cpu_in_data = d;
        i_pop       = pop;
        i_clr       = clr;
        @(posedge clk);
        model_step(wr, d, pop, clr);
        @(negedge clk);
        cpu_in_wr = 1'b0;
        i_pop     = 1'b0;
        i_clr     = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input logic [W-1:0] d);
        chk("head_before_pop", 32'(o_data), 32'(d));
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en && i_rst_n) begin
            chk("count", 32'(o_count), 32'(mq.size()));
            chk("empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("full", 32'(cpu_in_full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("underflow", 32'(o_underflow), 32'(m_udf));
            if (mq.size() != 0) chk("data", 32'(o_data), 32'(mq[0]));
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_full", 32'(cpu_in_full), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_udf", 32'(o_underflow), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;

        // Single push then pop
        push(8'h23);
        chk("p1_empty", 32'(o_empty), 32'd0);
        chk("p1_data", 32'(o_data), 32'h23);
        chk("p1_count", 32'(o_count), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("p1_empty_after_pop", 32'(o_empty), 32'd1);
        chk("p1_count_after_pop", 32'(o_count), 32'd0);

        // Ordering and wrap
        push(8'h15);
        push(8'h11);
        push(8'h22);
        chk("ord_head", 32'(o_data), 32'h15);
        cycle(1'b1, 8'h30, 1'b1, 1'b0);
        chk("ord_head2", 32'(o_data), 32'h11);
        cycle(1'b1, 8'h31, 1'b1, 1'b0);
        chk("ord_head3", 32'(o_data), 32'h22);
        cycle(1'b1, 8'h32, 1'b1, 1'b0);
        for (int i = 3; i < 8; i++) push(8'(8'h30 + i));
        chk("ord_count", 32'(o_count), 32'd8);
        for (int i = 0; i < 8; i++) pop_expect(8'(8'h30 + i));
        chk("ord_ovf", 32'(o_overflow), 32'd0);
        chk("ord_udf", 32'(o_underflow), 32'd0);

        // Full and overflow
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        chk("full_flag", 32'(cpu_in_full), 32'd1);
        chk("full_count", 32'(o_count), 32'd8);
        push(8'h99);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd8);
        pop_expect(8'h40);
        chk("full_fall", 32'(cpu_in_full), 32'd0);
        for (int i = 1; i < 8; i++) pop_expect(8'(8'h40 + i));
        chk("drain_empty", 32'(o_empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Simultaneous push+pop with count 3
        push(8'h01);
        push(8'h02);
        push(8'h03);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("sim_count", 32'(o_count), 32'd3);
        pop_expect(8'h02);
        pop_expect(8'h03);
        pop_expect(8'h55);
        // Simultaneous push+pop when empty
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        chk("sim_e_count", 32'(o_count), 32'd1);
        chk("sim_e_data", 32'(o_data), 32'h66);
        chk("sim_e_udf", 32'(o_underflow), 32'd1);

        // Clear priority
        for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
        chk("clr_pre_count", 32'(o_count), 32'd5);
        cycle(1'b1, 8'h88, 1'b1, 1'b1);
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_empty", 32'(o_empty), 32'd1);
        chk("clr_ovf", 32'(o_overflow), 32'd0);
        chk("clr_udf", 32'(o_underflow), 32'd0);
        push(8'h77);
        chk("clr_next", 32'(o_data), 32'h77);

        // Async reset mid-operation: count 4, overflow set
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        push(8'hEE);
        for (int i = 0; i < 4; i++) pop_expect(8'(8'h80 + i));
        chk("ar_pre_count", 32'(o_count), 32'd4);
        chk("ar_pre_ovf", 32'(o_overflow), 32'd1);
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_empty", 32'(o_empty), 32'd1);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_ovf", 32'(o_overflow), 32'd0);
        chk("ar_full", 32'(cpu_in_full), 32'd0);
        #1 i_rst_n = 1'b1;
        @(negedge clk);
        push(8'hA5);
        chk("ar_rt_data", 32'(o_data), 32'hA5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("ar_rt_empty", 32'(o_empty), 32'd1);

        // Random traffic, including occasional clears and resets
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 350) begin
                #2 i_rst_n = 1'b0;
                model_reset();
                #2 i_rst_n = 1'b1;
                @(negedge clk);
            end
            cycle(1'($urandom_range(0, 99) < 55), 8'($urandom),
                  1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hrm_inbox.md
# hrm_inbox

Synchronous mailbox FIFO on the responder side of the HRM CPU INBOX port. It accepts bytes pushed by a host or testbench via the `cpu_in_wr` / `cpu_in_data` / `cpu_in_full` handshake. It presents them first-word-fall-through to the CPU datapath, which pops one entry per executed INBOX instruction. It also provides occupancy and sticky error flags for debug visibility.

## Interface
- `DEPTH_LOG2`, default 3: log2 of the entry count (3 gives 8 entries). Legal range is 1..8.
- `WIDTH`, default 8: data word width.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `cpu_in_wr`  in  1  host push strobe, sampled on each rising edge.
- `cpu_in_data`  in  WIDTH  host push data.
- `cpu_in_full`  out  1  FIFO holds DEPTH entries.
- `i_pop`  in  1  CPU pop strobe, sampled on each rising edge.
- `o_data`  out  WIDTH  head entry, valid while `o_empty`=0.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_count`  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- `i_clr`  in  1  synchronous flush.
- `o_overflow`  out  1  sticky flag: a push was dropped.
- `o_underflow`  out  1  sticky flag: a pop was ignored.

## Operation
- Storage is a register array of DEPTH x WIDTH, with write pointer `wp`, read pointer `rp` (each DEPTH_LOG2 bits, wrapping modulo DEPTH) and counter `cnt`.
- A push is accepted iff `cpu_in_wr`=1 and `cnt`<DEPTH before the edge. On acceptance: `mem[wp]`<=`cpu_in_data`, then `wp`++.
- A pop is accepted iff `i_pop`=1 and `cnt`>0 before the edge. On acceptance: `rp`++.
- Counter update:
  - `cnt` += 1 for a push alone.
  - `cnt` -= 1 for a pop alone.
  - `cnt` is unchanged when both are accepted or neither is.
- When push and pop are both accepted in the same cycle and `wp`==`rp`, the pop retires the old head and the new word lands in the just-freed slot. This is legal only when the FIFO is full, and that case is excluded by the push rule.
- Full with push and pop together: the pop is accepted, the push is dropped, `o_overflow`<=1. The host must observe `cpu_in_full` before pushing.
- Empty with push and pop together: the push is accepted, the pop is ignored, `o_underflow`<=1.
- Push while full (no pop): the data is discarded, `o_overflow`<=1, and pointers and `cnt` are unchanged.
- Pop while empty: `o_underflow`<=1 and nothing else changes.
- `i_clr`=1: `wp`,`rp`,`cnt`<=0 and both sticky flags are cleared. `i_clr` has priority over a simultaneous push or pop, which are discarded and do not set flags. Array contents are not cleared.
- `o_data` = `mem[rp]` (combinational mux). It is don't-care when empty, and the bench must not check it then.
- `cpu_in_full` = (`cnt`==DEPTH); `o_empty` = (`cnt`==0); `o_count` = `cnt`. All are decoded from registers and are glitch-free relative to `clk`.

## Timing
- Reset (`i_rst_n`=0) takes effect immediately regardless of `clk`:
  - `wp`,`rp`,`cnt`<=0, so `o_empty`=1, `cpu_in_full`=0, `o_count`=0.
  - `o_overflow`=0, `o_underflow`=0.
- Reset deassertion is synchronised externally. The block accepts its first push on the first rising edge with `i_rst_n`=1.
- A reset mid-stream discards all content. A push or pop coincident with the reset edge has no effect.
- Push latency: a word pushed at edge N is on `o_data` and `o_empty`=0 immediately after edge N, so the CPU can pop it at edge N+1.
- Pop latency: after a pop at edge N, `o_data` shows the next entry immediately after edge N.
- `cpu_in_full` rises after the edge accepting the DEPTH-th push and falls after the next accepted pop.
- Throughput: one push and one pop per cycle, sustained, whenever 0<`cnt`<DEPTH.
- A strobe held high for k cycles is k requests. The host issues one-cycle pulses per byte.

## Test plan
- Reset then single push: release `i_rst_n`, push 0x23 for one cycle. Required: `o_empty`=0, `o_data`=0x23, `o_count`=1 after that edge. Pop once: `o_empty`=1, `o_count`=0.
- Ordering and wrap: push 0x15, 0x11, 0x22, then pop 3 and push 8 more (0x30..0x37) interleaved. Required: pops return 0x15, 0x11, 0x22, 0x30..0x37 in order, the pointers wrap past 7, and no flag is set.
- Full and overflow (DEPTH 8): push 0x40..0x47. Required: `cpu_in_full`=1 and `o_count`=8. Then push 0x99. Required: `o_overflow`=1 and count still 8; draining returns 0x40..0x47, with no 0x99.
- Simultaneous events:
  - With count 3, assert push 0x55 and pop together. Required: count stays 3, the old head is retired, 0x55 is at the tail.
  - When empty, push 0x66 and pop together. Required: count 1, `o_data`=0x66, `o_underflow`=1.
- Clear priority: with count 5, assert `i_clr`, push and pop together. Required: count 0, `o_empty`=1, flags 0, and the next push 0x77 appears at `o_data`.
- Async reset mid-operation: with count 4 and `o_overflow`=1, pulse `i_rst_n` low between clock edges. Required: outputs go to reset values before the next edge, and a subsequent push and pop of 0xA5 round-trips correctly.
